lane_tick_scheduler: RTL and testbench

LANE_TICK_SCHEDULER -- requirements
Module: lane_tick_scheduler

---
 rtl/lane_tick_scheduler_if.sv | 33 +++
 rtl/lane_tick_scheduler.sv | 141 ++++++++++++++
 tb/tb_lane_tick_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_tick_scheduler_if.sv
// lane_tick_scheduler_if
//   Run control, configuration-write handshake and tick outputs of the lane
//   tick scheduler. Clock and reset are not part of the bundle.
//   i_Run        : advance (1) / pause (0)
//   i_Cfg_Valid  : config write request, held until o_Cfg_Ready
//   o_Cfg_Ready  : write can be accepted this cycle
//   i_Cfg_Lane   : target lane 0..3
//   i_Cfg_Period : new period in base ticks, 0 disables the lane
//   o_Base_Tick  : one-cycle pulse per base period
//   o_Lane_Tick  : one-cycle pulse per lane on period expiry
//   o_Running    : scheduler is in RUN
interface lane_tick_scheduler_if #(
  parameter int PERIOD_W = 8
);
  logic                i_Run;
  logic                i_Cfg_Valid;
  logic                o_Cfg_Ready;
  logic [1:0]          i_Cfg_Lane;
  logic [PERIOD_W-1:0] i_Cfg_Period;
  logic                o_Base_Tick;
  logic [3:0]          o_Lane_Tick;
  logic                o_Running;

  modport slave (
    input  i_Run, i_Cfg_Valid, i_Cfg_Lane, i_Cfg_Period,
    output o_Cfg_Ready, o_Base_Tick, o_Lane_Tick, o_Running
  );

  modport master (
    output i_Run, i_Cfg_Valid, i_Cfg_Lane, i_Cfg_Period,
    input  o_Cfg_Ready, o_Base_Tick, o_Lane_Tick, o_Running
  );
endinterface

// File: rtl/lane_tick_scheduler.sv
// lane_tick_scheduler
//   Prescaler producing a base tick every BASE_DIV cycles, plus four lanes
//   that each emit a tick every <period> base ticks. Configuration writes go
//   through a one-cycle APPLY state that commits the period to one lane.
//   i_Clk : clock, all logic on posedge
//   i_Rst : asynchronous active-high reset
//   bus   : lane_tick_scheduler_if.slave (run, config handshake, ticks)

// One lane: period register and down-counter stepped by the base tick.
module lts_lane #(
  parameter int PERIOD_W = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_base_tick,
  input  logic                i_commit,
  input  logic [PERIOD_W-1:0] i_new_period,
  output logic                o_tick
);
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // A disabled lane keeps its counter at 0, so it can never hit 1.
  assign o_tick = i_base_tick && (period_q != '0) && (cnt_q == PERIOD_W'(1));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (i_base_tick && (period_q != '0))
      cnt_d = (cnt_q == PERIOD_W'(1)) ? period_q : cnt_q - PERIOD_W'(1);
    // A commit always restarts the count from the new period; if the lane
    // expired this same cycle its tick above has already been emitted.
    if (i_commit) begin
      period_d = i_new_period;
      cnt_d    = i_new_period;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module lane_tick_scheduler #(
  parameter int BASE_DIV = 250000,
  parameter int PERIOD_W = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  lane_tick_scheduler_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int PRESC_W   = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_APPLY} state_t;

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;      // state to return to after APPLY
  logic [1:0]          lane_q, lane_d;    // latched write target
  logic [PERIOD_W-1:0] per_q, per_d;      // latched write period
  logic [PRESC_W-1:0]  presc_q, presc_d;

  logic                 cfg_ready;
  logic                 accept;
  logic                 advance;
  logic                 base_tick;
  logic [NUM_LANES-1:0] lane_commit;
  logic [NUM_LANES-1:0] lane_tick;

  assign cfg_ready = (state_q != S_APPLY);
  assign accept    = bus.i_Cfg_Valid && cfg_ready;
  // Time only moves in RUN, or in an APPLY cycle that interrupted RUN.
  assign advance   = (state_q == S_RUN) || ((state_q == S_APPLY) && (ret_q == S_RUN));
  assign base_tick = advance && (presc_q == PRESC_W'(BASE_DIV - 1));

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    lane_d  = lane_q;
    per_d   = per_q;
    presc_d = presc_q;

    if (advance)
      presc_d = base_tick ? '0 : presc_q + PRESC_W'(1);

    if (accept) begin
      state_d = S_APPLY;
      ret_d   = state_q;
      lane_d  = bus.i_Cfg_Lane;
      per_d   = bus.i_Cfg_Period;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.i_Run)  state_d = S_RUN;
        S_RUN:   if (!bus.i_Run) state_d = S_PAUSE;
        S_PAUSE: if (bus.i_Run)  state_d = S_RUN;
        S_APPLY: state_d = ret_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      lane_q  <= '0;
      per_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      lane_q  <= lane_d;
      per_q   <= per_d;
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_commit[g] = (state_q == S_APPLY) && (lane_q == 2'(g));

    lts_lane #(.PERIOD_W(PERIOD_W)) u_lane (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_base_tick  (base_tick),
      .i_commit     (lane_commit[g]),
      .i_new_period (per_q),
      .o_tick       (lane_tick[g])
    );
  end

  assign bus.o_Cfg_Ready = cfg_ready;
  assign bus.o_Base_Tick = base_tick;
  assign bus.o_Lane_Tick = lane_tick;
  assign bus.o_Running   = (state_q == S_RUN);
endmodule

// File: tb/tb_lane_tick_scheduler.sv
module tb_lane_tick_scheduler;
  localparam int BD = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lane_tick_scheduler_if #(.PERIOD_W(PW)) bus ();

  lane_tick_scheduler #(.BASE_DIV(BD), .PERIOD_W(PW)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: time is counted as total advancing cycles and total base
  // ticks; each lane remembers the index of the base tick on which it is due.
  int m_st, m_ret, m_lane, m_pval;   // 0 idle, 1 run, 2 pause, 3 apply
  int m_adv, m_bcnt;
  int m_per[4];
  int m_due[4];

  function automatic bit m_advancing();
    return (m_st == 1) || (m_st == 3 && m_ret == 1);
  endfunction

  function automatic bit m_base();
    return m_advancing() && ((m_adv % BD) == BD - 1);
  endfunction

  function automatic logic [3:0] m_ticks();
    logic [3:0] t;
    t = '0;
    if (m_base())
      for (int i = 0; i < 4; i++) t[i] = (m_per[i] != 0) && (m_due[i] == m_bcnt);
    return t;
  endfunction

  task automatic m_reset();
    m_st = 0; m_ret = 0; m_lane = 0; m_pval = 0; m_adv = 0; m_bcnt = 0;
    for (int i = 0; i < 4; i++) begin m_per[i] = 0; m_due[i] = 0; end
  endtask

  task automatic m_step(input bit run, input bit valid, input int lane, input int per);
    bit b;
    bit adv;
    logic [3:0] t;
    b = m_base();
    adv = m_advancing();
    t = m_ticks();
    for (int i = 0; i < 4; i++) if (t[i]) m_due[i] = m_bcnt + m_per[i];
    if (m_st == 3) begin
      m_per[m_lane] = m_pval;
      m_due[m_lane] = b ? m_bcnt + m_pval : m_bcnt + m_pval - 1;
    end
    if (adv) m_adv++;
    if (b) m_bcnt++;
    if (valid && m_st != 3) begin
      m_ret = m_st; m_lane = lane; m_pval = per; m_st = 3;
    end else begin
      case (m_st)
        0: if (run) m_st = 1;
        1: if (!run) m_st = 2;
        2: if (run) m_st = 1;
        default: m_st = m_ret;
      endcase
    end
  endtask

  // Observed-output bookkeeping for the directed checks.
  int base_cnt = 0;
  int tick_cnt[4] = '{0, 0, 0, 0};
  int run_since_base = 0;
  int last_gap = 0;

  task automatic observe();
    if (bus.o_Running) run_since_base++;
    if (bus.o_Base_Tick) begin
      base_cnt++;
      last_gap = run_since_base;
      run_since_base = 0;
    end
    for (int i = 0; i < 4; i++) if (bus.o_Lane_Tick[i]) tick_cnt[i]++;
  endtask

  // One cycle: drive, compare against the model, clock, advance the model.
  task automatic cyc(input bit run, input bit valid, input int lane, input int per, input string tag);
    bus.i_Run = run;
    bus.i_Cfg_Valid = valid;
    bus.i_Cfg_Lane = 2'(lane);
    bus.i_Cfg_Period = PW'(per);
    observe();
    chk({tag, " ready"},   bus.o_Cfg_Ready, (m_st != 3));
    chk({tag, " running"}, bus.o_Running,   (m_st == 1));
    chk({tag, " base"},    bus.o_Base_Tick, m_base());
    chk({tag, " lane"},    bus.o_Lane_Tick, m_ticks());
    @(posedge clk);
    m_step(run, valid, lane, per);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, " rst ready"},   bus.o_Cfg_Ready, 1);
    chk({tag, " rst running"}, bus.o_Running,   0);
    chk({tag, " rst base"},    bus.o_Base_Tick, 0);
    chk({tag, " rst lane"},    bus.o_Lane_Tick, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit run; bit valid; int lane; int per;
    bit rdy; bit running; bit base; logic [3:0] lt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    int n;
    int b0;
    int t0[4];
    int pers[6];
    pers = '{0, 1, 2, 3, 5, 7};

    // Lane 0 period 3 from reset: base every 4 cycles, lane0 on every 3rd.
    //          run valid lane per  rdy run  base lt
    tbl[0]  = '{0, 1, 0, 3,  1, 0, 0, 4'b0000};
    tbl[1]  = '{1, 0, 0, 0,  0, 0, 0, 4'b0000};
    tbl[2]  = '{1, 0, 0, 0,  1, 0, 0, 4'b0000};
    tbl[3]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[4]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[5]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[6]  = '{1, 0, 0, 0,  1, 1, 1, 4'b0000};
    tbl[7]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[8]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[9]  = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[10] = '{1, 0, 0, 0,  1, 1, 1, 4'b0000};
    tbl[11] = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[12] = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[13] = '{1, 0, 0, 0,  1, 1, 0, 4'b0000};
    tbl[14] = '{1, 0, 0, 0,  1, 1, 1, 4'b0001};

    bus.i_Run = 1'b0; bus.i_Cfg_Valid = 1'b0; bus.i_Cfg_Lane = '0; bus.i_Cfg_Period = '0;
    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < 15; i++) begin
      bus.i_Run = tbl[i].run;
      bus.i_Cfg_Valid = tbl[i].valid;
      bus.i_Cfg_Lane = 2'(tbl[i].lane);
      bus.i_Cfg_Period = PW'(tbl[i].per);
      chk($sformatf("tbl%0d ready", i),   bus.o_Cfg_Ready, tbl[i].rdy);
      chk($sformatf("tbl%0d running", i), bus.o_Running,   tbl[i].running);
      chk($sformatf("tbl%0d base", i),    bus.o_Base_Tick, tbl[i].base);
      chk($sformatf("tbl%0d lane", i),    bus.o_Lane_Tick, tbl[i].lt);
      @(posedge clk);
      m_step(tbl[i].run, tbl[i].valid, tbl[i].lane, tbl[i].per);
      @(negedge clk);
    end
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, "l0run");

    // Periods 1,2,3,0 on lanes 0..3, then count over 12 base ticks.
    do_reset("multi");
    for (int l = 0; l < 4; l++) begin
      cyc(0, 1, l, (l == 3) ? 0 : l + 1, "mwr");
      cyc(0, 0, 0, 0, "mapply");
    end
    b0 = base_cnt;
    for (int i = 0; i < 4; i++) t0[i] = tick_cnt[i];
    n = 0;
    while (base_cnt - b0 < 12 && n < 100) begin
      cyc(1, 0, 0, 0, "multi");
      n++;
    end
    chk("multi bound", (base_cnt - b0 >= 12), 1);
    chk("multi lane0", tick_cnt[0] - t0[0], 12);
    chk("multi lane1", tick_cnt[1] - t0[1], 6);
    chk("multi lane2", tick_cnt[2] - t0[2], 4);
    chk("multi lane3", tick_cnt[3] - t0[3], 0);

    // Pause mid-count for 10 cycles: no ticks, count resumes where it left.
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, "prepause");
    b0 = base_cnt;
    for (int i = 0; i < 4; i++) t0[i] = tick_cnt[i];
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "pause");
    observe();
    chk("pause base", base_cnt - b0 - (bus.o_Base_Tick ? 1 : 0), 0);
    base_cnt -= bus.o_Base_Tick ? 1 : 0;
    for (int i = 0; i < 4; i++) tick_cnt[i] -= bus.o_Lane_Tick[i] ? 1 : 0;
    run_since_base -= bus.o_Running ? 1 : 0;
    chk("pause lane ticks", (tick_cnt[0] + tick_cnt[1] + tick_cnt[2]) - (t0[0] + t0[1] + t0[2]), 0);
    b0 = base_cnt;
    n = 0;
    while (base_cnt == b0 && n < 20) begin
      cyc(1, 0, 0, 0, "resume");
      n++;
    end
    chk("resume bound", (base_cnt != b0), 1);
    chk("resume gap", last_gap, BD);

    // Rewrite lane1 2->5 so the commit lands on lane1's expiring base tick.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_st == 1 && (m_adv % BD) == BD - 2 && m_per[1] != 0 && m_due[1] == m_bcnt) found = 1;
      else cyc(1, 0, 0, 0, "seek");
    end
    chk("rewrite seek", found, 1);
    cyc(1, 1, 1, 5, "rewr");
    chk("rewrite apply tick", bus.o_Lane_Tick[1], 1);
    cyc(1, 0, 0, 0, "rapply");
    n = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.o_Base_Tick) n++;
      if (bus.o_Lane_Tick[1]) found = 1;
      else cyc(1, 0, 0, 0, "rwait");
    end
    chk("rewrite next found", found, 1);
    chk("rewrite base gap", n, 5);

    // Back-to-back writes with valid held high.
    chk("b2b ready0", bus.o_Cfg_Ready, 1);
    cyc(1, 1, 2, 4, "b2b0");
    chk("b2b ready1", bus.o_Cfg_Ready, 0);
    cyc(1, 1, 3, 6, "b2b1");
    chk("b2b ready2", bus.o_Cfg_Ready, 1);
    cyc(1, 1, 3, 6, "b2b2");
    chk("b2b ready3", bus.o_Cfg_Ready, 0);
    cyc(1, 0, 0, 0, "b2b3");
    for (int i = 0; i < 80; i++) cyc(1, 0, 0, 0, "b2brun");

    // Randomized traffic against the model.
    do_reset("rand");
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3), pers[$urandom_range(0, 5)], "rand");

    // Reset during APPLY clears outputs at once and disables every lane.
    cyc(1, 1, 0, 1, "rstwr");
    chk("apply before rst", bus.o_Cfg_Ready, 0);
    do_reset("apply");
    for (int i = 0; i < 4; i++) t0[i] = tick_cnt[i];
    b0 = base_cnt;
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, "postrst");
    chk("postrst base seen", (base_cnt > b0), 1);
    chk("postrst lane ticks",
        (tick_cnt[0] + tick_cnt[1] + tick_cnt[2] + tick_cnt[3]) - (t0[0] + t0[1] + t0[2] + t0[3]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
